ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-master arbiter for the SoC data RAM, which is built from four byte-lane dual-port RAMs with 1-cycle synchronous read.
- Master 0 is the core load/store port. Master 1 is the JTAG debug-module system-bus port.
- Round-robin grant, one transaction accepted per cycle, byte-strobe writes, address-window check with error response.
- Sits between riscv core / jtag debug module and ram_inst inside riscv_soc.

Parameters:
- ADDR_W, 11, RAM word-address width (2^11 words = 8 KiB).
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 2^(ADDR_W+2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- m0_req  in  1  master 0 request valid
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes, bit n enables lane n
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_rvalid  out  1  master 0 response valid
- m0_rdata  out  32  master 0 read data
- m0_err  out  1  master 0 response error (address outside window)
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1
- ram_en  out  1  RAM access enable
- ram_we  out  4  per-lane write enables (ram_byte0..3)
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Handshake: a request is accepted in any cycle where mN_req=1 and mN_gnt=1. gnt is combinational from req, the round-robin pointer and the DBG_PRIO_EN rule. The master holds its request fields stable until gnt. The RAM is always ready, so one acceptance per cycle is guaranteed.
- Arbitration: single requester always wins. When both request, the master not granted last wins. The rr_ptr register records the last winner and is updated on each acceptance; after reset it is set so that m0 wins the first tie.
- Address check: in-window when (addr - BASE_ADDR) < 2^(ADDR_W+2). ram_addr = (addr - BASE_ADDR)[ADDR_W+1:2]; addr[1:0] is ignored.
- RAM drive on an in-window acceptance: ram_en=1; ram_we = wstrb if we=1, else 4'b0; ram_wdata = wdata.
- Out-of-window acceptance: ram_en=0 and ram_we=0. The request is still granted and answered.
- Response pipeline: one stage of registers (resp_valid, resp_id, resp_err, resp_rd). Response appears exactly 1 cycle after acceptance on the owner's rvalid. Reads of the window return rdata=ram_rdata. Writes and errors return rdata=32'h0. err=1 only for out-of-window accesses.
- Write with wstrb=0: no lane written, ack still returned.
- Back-to-back: accept in cycle N and N+1; responses in N+1 and N+2. No bubbles, no stall path.
- Idle: ram_en=0, ram_we=0, ram_addr/ram_wdata hold 0.
- Reset (including mid-transaction): all outputs 0, response register cleared, pending response dropped, rr_ptr reset. A request accepted in the same cycle rstn=0 is discarded.

Optional Feature:
- RAM_ARB_DBG_PRIO_EN defined: master 1 (debug) has absolute priority on ties, and rr_ptr is unused.
- Undefined: round-robin as above.

Decomposition:
- Shared defines (defines.v): master IDs `MST_CORE=1'b0 / `MST_DBG=1'b1`, `ZeroWord`, RAM default width constant.
- One sub-module, rr_arb2: 2-input round-robin grant with rr_ptr register and priority override. The top keeps the address decode and response pipeline.

Test Plan:
- m0 read at 0x0000_0010 with RAM word 4 = 0xDEADBEEF -> m0_gnt same cycle; ram_addr=4; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0.
- m1 write 0x0000_0020, wdata 0x11223344, wstrb 4'b0101 -> ram_we=4'b0101, ram_addr=8; next cycle m1_rvalid=1, rdata=0. A read-back gives 0xAA22BB44 when the prior word was 0xAAAABBBB.
- Both masters request continuously for 4 cycles from reset -> grants m0, m1, m0, m1; each rvalid one cycle after its grant. With RAM_ARB_DBG_PRIO_EN: m1 every cycle, m0_gnt=0.
- m0 read at 0x0000_2000 (BASE=0, ADDR_W=11) -> gnt, ram_en=0; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0.
- Accept an m0 read, assert rstn=0 the next cycle -> m0_rvalid=0 and all outputs 0. After release, a tie grants m0 first.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared master IDs, zero word, default RAM width
// and the response-stage bundle used by ram_arbiter.
package ram_arbiter_pkg;

  localparam logic        MST_CORE   = 1'b0;
  localparam logic        MST_DBG    = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0;
  localparam int          RAM_ADDR_W = 11;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
    logic rd;
  } resp_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// ram_arbiter_rr_arb2: two-input round-robin grant with last-winner pointer.
// Ports: clk, rstn (sync, active-low), req0_i/req1_i in, gnt0_o/gnt1_o out.
// RAM_ARB_DBG_PRIO_EN: input 1 wins every tie; the pointer is not built.
module ram_arbiter_rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic tie_to1;

`ifdef RAM_ARB_DBG_PRIO_EN
  assign tie_to1 = 1'b1;

  logic unused_clk;
  assign unused_clk = clk;
`else
  logic rr_ptr_q;
  logic rr_ptr_d;

  // Tie goes to the master that did not win last.
  assign tie_to1 = (rr_ptr_q == MST_CORE);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt1_o)
      rr_ptr_d = MST_DBG;
    else if (gnt0_o)
      rr_ptr_d = MST_CORE;
  end

  // Reset value marks master 1 as last winner so master 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rstn)
      rr_ptr_q <= MST_DBG;
    else
      rr_ptr_q <= rr_ptr_d;
  end
`endif

  // No grants while in reset: a request seen then is simply dropped.
  assign gnt1_o = rstn & req1_i & (~req0_i | tie_to1);
  assign gnt0_o = rstn & req0_i & (~req1_i | ~tie_to1);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter for the byte-lane data RAM (1-cycle read).
// Ports: clk, rstn, m0_*/m1_* request/response, ram_* RAM drive. Optional
// RAM_ARB_DBG_PRIO_EN gives master 1 (debug) absolute tie priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int          ADDR_W    = RAM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic        acc;
  logic        sel_we;
  logic [29:0] sel_wa;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_strb;
  logic [29:0] woff;
  logic        in_win;
  resp_t       resp_q;
  resp_t       resp_d;
  logic        rv0;
  logic        rv1;

  logic unused_lsb;
  assign unused_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

  ram_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .gnt0_o (m0_gnt),
    .gnt1_o (m1_gnt)
  );

  assign acc       = m0_gnt | m1_gnt;
  assign sel_we    = m1_gnt ? m1_we          : m0_we;
  assign sel_wa    = m1_gnt ? m1_addr[31:2]  : m0_addr[31:2];
  assign sel_wdata = m1_gnt ? m1_wdata       : m0_wdata;
  assign sel_strb  = m1_gnt ? m1_wstrb       : m0_wstrb;

  // BASE_ADDR is window-aligned, so a word-level subtract is exact.
  assign woff   = sel_wa - BASE_ADDR[31:2];
  assign in_win = ((woff >> ADDR_W) == 30'd0);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = ZERO_WORD;
    if (acc && in_win) begin
      ram_en    = 1'b1;
      ram_we    = sel_we ? sel_strb : 4'b0000;
      ram_addr  = woff[ADDR_W-1:0];
      ram_wdata = sel_wdata;
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = acc;
    resp_d.id    = m1_gnt ? MST_DBG : MST_CORE;
    resp_d.err   = acc & ~in_win;
    resp_d.rd    = acc & in_win & ~sel_we;
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      resp_q <= '0;
    else
      resp_q <= resp_d;
  end

  // Gating by rstn keeps outputs quiet in the reset cycle itself.
  assign rv0 = rstn & resp_q.valid & (resp_q.id == MST_CORE);
  assign rv1 = rstn & resp_q.valid & (resp_q.id == MST_DBG);

  assign m0_rvalid = rv0;
  assign m1_rvalid = rv1;
  assign m0_err    = rv0 & resp_q.err;
  assign m1_err    = rv1 & resp_q.err;
  assign m0_rdata  = (rv0 && resp_q.rd) ? ram_rdata : ZERO_WORD;
  assign m1_rdata  = (rv1 && resp_q.rd) ? ram_rdata : ZERO_WORD;

endmodule
